// File: rtl/seq_scan_controller.sv
// ----------------------------------------------------------------------------
// seq_scan_controller
//
// Purpose:
//   Feeds parallel words, one bit per clock and MSB first, into an external
//   overlapping "101" serial detector. The detector has a Moore-style
//   registered output. The controller clears the detector before every word,
//   so a match can never span two words. It collects the detector's hit flag
//   for every bit and returns a per-bit hit mask plus a hit count over a
//   valid/ready result handshake.
//
//   Sequence per word: IDLE -> CLEAR (1) -> SHIFT (WIDTH) -> DRAIN (1) -> DONE.
//   An abort in any non-IDLE state discards the word. It costs one extra
//   detector-clear cycle (ABORT) and then returns to IDLE.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   host presents in_word
//   in_ready   out  controller can accept a word (IDLE only)
//   in_word    in   word to scan, bit WIDTH-1 shifted first
//   abort      in   synchronous cancel of the current scan
//   det_clear  out  registered active-high clear to the detector
//   det_data   out  registered serial bit to the detector
//   det_hit    in   detector output, high the cycle after a completed "101"
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out_hits   out  bit i set if a pattern ended on in_word[i]
//   out_count  out  popcount of out_hits
//   busy       out  high in any state other than IDLE
// ----------------------------------------------------------------------------
module seq_scan_controller #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic             abort,
    output logic             det_clear,
    output logic             det_data,
    input  logic             det_hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hits,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StDrain,
        StDone,
        StAbort
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hits_q;
    logic [CNT_W-1:0]   count_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               det_clear_q;
    logic               det_data_q;
    logic               busy_q;

    // The hit seen while cnt_q = k belongs to the bit shifted out when the
    // counter was k-1. That bit is in_word[WIDTH-k].
    logic [CNT_W-1:0]   hit_idx;
    logic [WIDTH-1:0]   hit_mask;

    always_comb begin
        hit_idx  = CNT_W'(WIDTH) - cnt_q;
        hit_mask = {{(WIDTH - 1){1'b0}}, 1'b1} << hit_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            hits_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            det_clear_q <= 1'b0;
            det_data_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (abort && (state_q != StIdle) && (state_q != StAbort)) begin
            // Abort wins over everything else, including out_ready in DONE.
            // The partial or finished result is dropped.
            state_q     <= StAbort;
            hits_q      <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            det_clear_q <= 1'b1;
            det_data_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        shift_q     <= in_word;
                        hits_q      <= '0;
                        count_q     <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        det_clear_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StClear;
                    end
                end

                StClear: begin
                    // Put the MSB on the line so it is valid for the first
                    // SHIFT cycle.
                    det_clear_q <= 1'b0;
                    det_data_q  <= shift_q[WIDTH-1];
                    shift_q     <= {shift_q[WIDTH-2:0], 1'b0};
                    cnt_q       <= '0;
                    state_q     <= StShift;
                end

                StShift: begin
                    // In the first SHIFT cycle the detector has just been
                    // cleared, so that cycle's hit is ignored.
                    if ((cnt_q != '0) && det_hit) begin
                        hits_q  <= hits_q | hit_mask;
                        count_q <= count_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        det_data_q <= 1'b0;
                        state_q    <= StDrain;
                    end else begin
                        det_data_q <= shift_q[WIDTH-1];
                        shift_q    <= {shift_q[WIDTH-2:0], 1'b0};
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end

                StDrain: begin
                    // The hit for the last bit, in_word[0], only shows up here.
                    if (det_hit) begin
                        hits_q  <= hits_q | {{(WIDTH - 1){1'b0}}, 1'b1};
                        count_q <= count_q + CNT_W'(1);
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end

                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                StAbort: begin
                    det_clear_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end

                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    det_clear_q <= 1'b0;
                    det_data_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_hits  = hits_q;
    assign out_count = count_q;
    assign det_clear = det_clear_q;
    assign det_data  = det_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_seq_scan_controller
//
// Directed bench for seq_scan_controller (WIDTH=8). It contains a behavioural
// overlapping "101" Moore detector with a registered output, a synchronous
// clear and an asynchronous reset. Expected hit masks are worked out by hand
// from the bit sequences.
// ----------------------------------------------------------------------------
module tb_seq_scan_controller;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_word;
    logic          abort;
    logic          det_clear;
    logic          det_data;
    logic          det_hit;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_hits;
    logic [CW-1:0] out_count;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_scan_controller #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .abort     (abort),
        .det_clear (det_clear),
        .det_data  (det_data),
        .det_hit   (det_hit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hits  (out_hits),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector states: 0 = nothing, 1 = seen "1", 2 = seen "10".
    logic [1:0] dst_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_q   <= 2'd0;
            det_hit <= 1'b0;
        end else if (det_clear) begin
            dst_q   <= 2'd0;
            det_hit <= 1'b0;
        end else begin
            det_hit <= (dst_q == 2'd2) && det_data;
            dst_q   <= det_data ? 2'd1 : ((dst_q == 2'd1) ? 2'd2 : 2'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Send one word and follow it to completion. hold = cycles out_ready stays
    // low after out_valid rises.
    task automatic run_word(input string tag, input logic [W-1:0] word,
                            input logic [W-1:0] exp_hits, input int exp_cnt,
                            input int hold);
        logic [W-1:0] seq;
        int lat, clr0, clr_extra, dd_bad, rdy_hi, hold_bad;
        lat = -1; clr0 = 0; clr_extra = 0; dd_bad = 0; rdy_hi = 0; hold_bad = 0;
        seq = '0;
        @(negedge clk);
        check({tag, " in_ready before accept"}, in_ready, 1);
        in_valid = 1'b1;
        in_word  = word;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = '0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) clr0 = int'(det_clear);
            else if (det_clear) clr_extra++;
            if (c >= 1 && c <= W) seq[W-c] = det_data;
            else if (det_data) dd_bad++;
            if (in_ready) rdy_hi++;
            if (out_valid) lat = c;
        end
        check({tag, " det_clear in CLEAR"}, clr0, 1);
        check({tag, " det_clear extra cycles"}, clr_extra, 0);
        check({tag, " det_data sequence"}, seq, word);
        check({tag, " det_data outside SHIFT"}, dd_bad, 0);
        check({tag, " in_ready during scan"}, rdy_hi, 0);
        check({tag, " latency"}, lat, W + 2);
        check({tag, " out_hits"}, out_hits, exp_hits);
        check({tag, " out_count"}, out_count, exp_cnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_hits !== exp_hits || out_count !== CW'(exp_cnt) || in_ready)
                hold_bad++;
        end
        check({tag, " held result"}, hold_bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after accept"}, out_valid, 0);
        check({tag, " in_ready after accept"}, in_ready, 1);
        check({tag, " busy after accept"}, busy, 0);
    endtask

    initial begin
        int bad;
        int seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset det_clear", det_clear, 0);
        check("reset det_data", det_data, 0);
        check("reset out_hits", out_hits, 0);
        check("reset out_count", out_count, 0);
        check("reset busy", busy, 0);
        reset = 1'b1;

        // 1: basic word, sequence 1,0,1,0,1,1,0,1 -> hits on bits 5,3,0
        run_word("t1", 8'b1010_1101, 8'b0010_1001, 3, 0);

        // 2: no pattern at all
        run_word("t2a", 8'hFF, 8'h00, 0, 0);
        run_word("t2b", 8'h00, 8'h00, 0, 0);

        // 3: sequence 0,1,0,1,0,1,0,1 -> hits on bits 4,2,0, result held
        run_word("t3", 8'b0101_0101, 8'b0001_0101, 3, 5);

        // 4: "101" only across the word boundary
        run_word("t4a", 8'b0000_0010, 8'h00, 0, 0);
        run_word("t4b", 8'b1000_0000, 8'h00, 0, 0);

        // abort in IDLE is ignored
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle abort in_ready", in_ready, 1);
        check("idle abort det_clear", det_clear, 0);

        // 5: abort sampled at the end of the 4th SHIFT cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 8'b1011_0110;
        @(posedge clk);
        @(negedge clk);              // CLEAR
        in_valid = 1'b0;
        repeat (4) @(negedge clk);   // SHIFT cycles 1..4
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("t5 abort det_clear", det_clear, 1);
        check("t5 abort det_data", det_data, 0);
        check("t5 abort in_ready", in_ready, 0);
        check("t5 abort busy", busy, 1);
        @(negedge clk);
        check("t5 idle det_clear", det_clear, 0);
        check("t5 idle in_ready", in_ready, 1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) bad++;
            @(negedge clk);
        end
        check("t5 out_valid never", bad, 0);
        run_word("t5b", 8'b1010_0000, 8'b0010_0000, 1, 0);

        // abort beats out_ready in DONE
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 8'b0000_0101;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        check("done abort reached DONE", seen, 1);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check("done abort det_clear", det_clear, 1);
        check("done abort out_valid", out_valid, 0);
        check("done abort in_ready", in_ready, 0);
        @(negedge clk);
        check("done abort back to idle", in_ready, 1);

        // 6: reset in the middle of SHIFT
        in_valid = 1'b1;
        in_word  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6 mid-shift det_data", det_data, 1);
        reset = 1'b0;
        #1;
        check("t6 reset in_ready", in_ready, 1);
        check("t6 reset busy", busy, 0);
        check("t6 reset det_data", det_data, 0);
        check("t6 reset det_clear", det_clear, 0);
        check("t6 reset out_valid", out_valid, 0);
        check("t6 reset out_count", out_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6 release in_ready", in_ready, 1);
        run_word("t6b", 8'b1010_1101, 8'b0010_1001, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
